cam_ctrl: RTL and testbench
===========================

// Module: cam_ctrl
// PURPOSE
//  Initiator-side controller for the cam block: owns its pin interface (enable, write, addr, data) and consumes its results (out, found).
//  Upstream logic issues write, search and fill commands over a valid/ready request channel.
//  Results come back on a valid/ready response channel. Only one command is in flight at a time.
//  Sits between the datapath and the cam instance; cam pins connect directly, no glue.
// PARAMETERS
//  ADDR_W      5   cam address width (matches cam addr/out)
//  DATA_W      8   cam data/key width
//  DEPTH       16  entries swept by FILL; legal range 1..2**ADDR_W
//  RESULT_LAT  1   cycles after the cam sampling edge before cam_out/cam_found are valid; legal range >=1
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       controller can accept; high only in IDLE
//  req_op      in   2       00 SEARCH, 01 WRITE, 10 FILL, 11 reserved
//  req_addr    in   ADDR_W  WRITE target address
//  req_data    in   DATA_W  SEARCH key / WRITE data / FILL value
//  resp_valid  out  1       response held until resp_ready
//  resp_ready  in   1       response consumed
//  resp_found  out  1       SEARCH hit flag; 1 for WRITE/FILL completion; 0 for reserved op
//  resp_addr   out  ADDR_W  SEARCH hit address; written address for WRITE; DEPTH-1 for FILL
//  cam_enable  out  1       to cam enable
//  cam_write   out  1       to cam write
//  cam_addr    out  ADDR_W  to cam addr
//  cam_data    out  DATA_W  to cam data
//  cam_out     in   ADDR_W  from cam out
//  cam_found   in   1       from cam found
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; resp_valid=resp_found=0; resp_addr=0; all cam_* outputs=0; fill counter=0.
//  - Reset mid-command aborts it: no further cam cycles, partial FILL is not resumed, no response is emitted.
//  - FSM states: IDLE, ISSUE, WAIT, FILL, RESP. Accept happens on an edge with req_valid & req_ready; op and data are latched there.
//  - IDLE -> SEARCH: ISSUE (1 cycle) drives cam_enable=1, cam_write=0, cam_data=key.
//  - ISSUE -> WAIT: count RESULT_LAT edges, then capture cam_found/cam_out into resp_* and go to RESP.
//  - SEARCH latency: accept edge N; resp_valid rises after edge N+1+RESULT_LAT.
//  - WRITE: ISSUE drives enable=1, write=1, addr, data for exactly one cycle, then RESP. resp_valid rises after edge N+2; resp_found=1, resp_addr=req_addr.
//  - FILL: for i=0..DEPTH-1, drive enable=1, write=1, addr=i, data=value, one entry per cycle back-to-back, then RESP.
//    The counter stops at DEPTH-1 and never wraps; resp_addr=DEPTH-1, resp_found=1.
//  - Reserved op 11: no cam activity; go straight to RESP with found=0, addr=0.
//  - RESP: resp_* stable while resp_valid & !resp_ready. The handshake edge clears resp_valid and returns to IDLE.
//    req_ready rises in the cycle after the handshake; there is no same-cycle turnaround.
//  - Outside ISSUE/FILL: cam_enable=cam_write=0. cam_addr/cam_data hold their last value.
//  - req_* inputs are ignored while req_ready=0; upstream holds req_valid until accepted.
// CONFIGURATION
//  CAM_CTRL_STATS_EN defined:
//    - Adds outputs stat_hits[15:0] and stat_miss[15:0]: saturating counts of SEARCH responses with found=1 / found=0.
//    - Each count updates on the response handshake edge and is cleared by rst_n.
//  CAM_CTRL_STATS_EN undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Reset: rst_n=0 -> req_ready=1, resp_valid=0, cam_enable=0, cam_write=0.
//  2. WRITE addr=3 data=0x13, RESULT_LAT=1 -> one cycle of cam_enable=1, cam_write=1, cam_addr=3, cam_data=0x13; resp_valid after accept+2, found=1, addr=3.
//  3. WRITE 0x1F to addr 15, then SEARCH 0x1F -> cam_enable=1, cam_write=0 for one cycle; resp_valid exactly 2 cycles after accept, found=1, addr=15.
//  4. SEARCH 0x55 (absent) -> found=0. Hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0 throughout.
//  5. FILL 0xAA with DEPTH=16 -> 16 consecutive write cycles, addr 0..15; response addr=15; a following SEARCH 0xAA returns found=1.
//  6. rst_n=0 pulsed during FILL at i=7 -> cam_enable drops immediately, no response, req_ready=1; with CAM_CTRL_STATS_EN, stat_hits/stat_miss=0.

Source files
------------

// File: rtl/cam_ctrl.sv
// Initiator-side controller for a cam: sequences SEARCH/WRITE/FILL commands onto the cam pins
// and returns one response per command. Optional hit/miss counters under CAM_CTRL_STATS_EN.
module cam_ctrl #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RESULT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_found,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              cam_enable,
  output logic              cam_write,
  output logic [ADDR_W-1:0] cam_addr,
  output logic [DATA_W-1:0] cam_data,
  input  logic [ADDR_W-1:0] cam_out,
  input  logic              cam_found
`ifdef CAM_CTRL_STATS_EN
  ,
  output logic [15:0]       stat_hits,
  output logic [15:0]       stat_miss
`endif
);

  localparam int unsigned FILL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAT_W  = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  localparam int unsigned CNT_W  = (FILL_W > LAT_W) ? FILL_W : LAT_W;

  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_FILL   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FILL  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               req_ready_d, resp_valid_d, resp_found_d;
  logic [ADDR_W-1:0]  resp_addr_d, cam_addr_d;
  logic [DATA_W-1:0]  cam_data_d;
  logic               cam_enable_d, cam_write_d;
  logic               accept;

  assign accept = req_valid & req_ready;

  // State and registered outputs; every output is loaded from its next-value term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= OP_SEARCH;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_found <= 1'b0;
      resp_addr  <= '0;
      cam_enable <= 1'b0;
      cam_write  <= 1'b0;
      cam_addr   <= '0;
      cam_data   <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      op_q       <= op_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_found <= resp_found_d;
      resp_addr  <= resp_addr_d;
      cam_enable <= cam_enable_d;
      cam_write  <= cam_write_d;
      cam_addr   <= cam_addr_d;
      cam_data   <= cam_data_d;
    end
  end

  // Next-state logic; WRITE passes through WAIT for one cycle regardless of RESULT_LAT.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_SEARCH, OP_WRITE: state_d = S_ISSUE;
            OP_FILL:             state_d = S_FILL;
            default:             state_d = S_RESP;
          endcase
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if ((op_q == OP_WRITE) || (cnt == CNT_W'(RESULT_LAT - 1))) state_d = S_RESP;
      end
      S_FILL: begin
        if (cnt == CNT_W'(DEPTH - 1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; cam strobes default low, cam addr/data hold.
  always_comb begin
    cnt_d        = cnt;
    op_d         = op_q;
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = resp_valid;
    resp_found_d = resp_found;
    resp_addr_d  = resp_addr;
    cam_enable_d = 1'b0;
    cam_write_d  = 1'b0;
    cam_addr_d   = cam_addr;
    cam_data_d   = cam_data;
    case (state)
      S_IDLE: begin
        if (accept) begin
          op_d  = req_op;
          cnt_d = '0;
          case (req_op)
            OP_SEARCH: begin
              cam_enable_d = 1'b1;
              cam_data_d   = req_data;
            end
            OP_WRITE: begin
              cam_enable_d = 1'b1;
              cam_write_d  = 1'b1;
              cam_addr_d   = req_addr;
              cam_data_d   = req_data;
            end
            OP_FILL: begin
              cam_enable_d = 1'b1;
              cam_write_d  = 1'b1;
              cam_addr_d   = '0;
              cam_data_d   = req_data;
            end
            default: begin
              resp_valid_d = 1'b1;
              resp_found_d = 1'b0;
              resp_addr_d  = '0;
            end
          endcase
        end
      end
      S_WAIT: begin
        if (state_d == S_RESP) begin
          resp_valid_d = 1'b1;
          if (op_q == OP_WRITE) begin
            resp_found_d = 1'b1;
            resp_addr_d  = cam_addr;
          end else begin
            resp_found_d = cam_found;
            resp_addr_d  = cam_out;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_FILL: begin
        if (state_d == S_RESP) begin
          resp_valid_d = 1'b1;
          resp_found_d = 1'b1;
          resp_addr_d  = ADDR_W'(DEPTH - 1);
        end else begin
          cnt_d        = cnt + CNT_W'(1);
          cam_enable_d = 1'b1;
          cam_write_d  = 1'b1;
          cam_addr_d   = ADDR_W'(cnt + CNT_W'(1));
        end
      end
      S_RESP: begin
        if (resp_ready) resp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef CAM_CTRL_STATS_EN
  // Saturating SEARCH hit/miss counters, bumped on the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits <= '0;
      stat_miss <= '0;
    end else if (resp_valid && resp_ready && (op_q == OP_SEARCH)) begin
      if (resp_found) begin
        if (stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
      end else begin
        if (stat_miss != 16'hFFFF) stat_miss <= stat_miss + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: behavioural cam on the pins, command-level reference model for expected responses.
module tb_cam_ctrl;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned RESULT_LAT = 1;
  localparam int unsigned NENT       = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0, req_ready;
  logic [1:0]        req_op = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic              resp_valid, resp_ready = 1'b0, resp_found;
  logic [ADDR_W-1:0] resp_addr;
  logic              cam_enable, cam_write;
  logic [ADDR_W-1:0] cam_addr, cam_out;
  logic [DATA_W-1:0] cam_data;
  logic              cam_found;
`ifdef CAM_CTRL_STATS_EN
  logic [15:0]       stat_hits, stat_miss;
`endif

  int checks = 0;
  int failures = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  cam_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESULT_LAT(RESULT_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_found(resp_found), .resp_addr(resp_addr),
    .cam_enable(cam_enable), .cam_write(cam_write), .cam_addr(cam_addr),
    .cam_data(cam_data), .cam_out(cam_out), .cam_found(cam_found)
`ifdef CAM_CTRL_STATS_EN
    , .stat_hits(stat_hits), .stat_miss(stat_miss)
`endif
  );

  // Behavioural cam: writes and lowest-address searches sampled on the rising edge.
  logic [DATA_W-1:0] cam_mem [NENT];
  bit                cam_vld [NENT];
  initial begin
    for (int i = 0; i < int'(NENT); i++) cam_vld[i] = 1'b0;
    cam_out = '0;
    cam_found = 1'b0;
  end
  always @(posedge clk) begin
    if (cam_enable) begin
      if (cam_write) begin
        cam_mem[cam_addr] <= cam_data;
        cam_vld[cam_addr] <= 1'b1;
      end else begin
        logic hit;
        logic [ADDR_W-1:0] ha;
        hit = 1'b0;
        ha = '0;
        for (int i = int'(NENT) - 1; i >= 0; i--)
          if (cam_vld[i] && cam_mem[i] == cam_data) begin hit = 1'b1; ha = ADDR_W'(i); end
        cam_found <= hit;
        cam_out   <= ha;
      end
    end
  end

  // Command-level reference: contents as upstream intended them.
  logic [DATA_W-1:0] ref_mem [NENT];
  bit                ref_vld [NENT];

  task automatic ref_apply(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (op == 2'b01) begin ref_mem[a] = d; ref_vld[a] = 1'b1; end
    if (op == 2'b10) for (int i = 0; i < int'(DEPTH); i++) begin ref_mem[i] = d; ref_vld[i] = 1'b1; end
  endtask

  task automatic ref_search(input logic [DATA_W-1:0] key, output logic f, output logic [ADDR_W-1:0] a);
    f = 1'b0;
    a = '0;
    for (int i = 0; i < int'(NENT); i++)
      if (!f && ref_vld[i] && ref_mem[i] == key) begin f = 1'b1; a = ADDR_W'(i); end
  endtask

  function automatic int exp_lat(input logic [1:0] op);
    case (op)
      2'b00:   return 1 + int'(RESULT_LAT);
      2'b01:   return 2;
      2'b10:   return int'(DEPTH);
      default: return 0;
    endcase
  endfunction

  function automatic int exp_en(input logic [1:0] op);
    case (op)
      2'b00, 2'b01: return 1;
      2'b10:        return int'(DEPTH);
      default:      return 0;
    endcase
  endfunction

  // Observations of the most recent command.
  int                obs_lat, obs_en;
  bit                obs_timeout, obs_seq_err, obs_stable_err, obs_ready_err, obs_hs_err;
  logic              obs_found;
  logic [ADDR_W-1:0] obs_addr;

  // Drives one command, records cam pin activity, holds the response, then handshakes.
  task automatic run_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input int hold);
    int w;
    obs_lat = -1; obs_en = 0; obs_timeout = 0; obs_seq_err = 0;
    obs_stable_err = 0; obs_ready_err = 0; obs_hs_err = 0;
    obs_found = 1'bx; obs_addr = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) obs_timeout = 1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_addr = ADDR_W'($urandom); req_data = DATA_W'($urandom);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        obs_lat = c;
        if (cam_enable) obs_seq_err = 1;
        break;
      end
      if (cam_enable) begin
        if (c != obs_en) obs_seq_err = 1;
        case (op)
          2'b00:   if (cam_write !== 1'b0 || cam_data !== d) obs_seq_err = 1;
          2'b01:   if (cam_write !== 1'b1 || cam_addr !== a || cam_data !== d) obs_seq_err = 1;
          2'b10:   if (cam_write !== 1'b1 || cam_addr !== ADDR_W'(obs_en) || cam_data !== d) obs_seq_err = 1;
          default: obs_seq_err = 1;
        endcase
        obs_en++;
      end
    end
    if (obs_lat < 0) begin
      obs_timeout = 1;
    end else begin
      obs_found = resp_found;
      obs_addr  = resp_addr;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (resp_valid !== 1'b1 || resp_found !== obs_found || resp_addr !== obs_addr) obs_stable_err = 1;
        if (req_ready !== 1'b0 || cam_enable !== 1'b0) obs_ready_err = 1;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) obs_hs_err = 1;
      if (op == 2'b00) begin
        if (obs_found) exp_hits++; else exp_miss++;
      end
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || cam_enable !== 1'b0 || cam_write !== 1'b0 ||
        resp_found !== 1'b0 || resp_addr !== '0) begin
      failures++;
      $display("FAIL reset: ready=%b rvalid=%b en=%b wr=%b found=%b addr=%0d, want 1 0 0 0 0 0",
               req_ready, resp_valid, cam_enable, cam_write, resp_found, resp_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write;
    run_cmd(2'b01, 5'd3, 8'h13, 0);
    ref_apply(2'b01, 5'd3, 8'h13);
    checks++;
    if (obs_timeout || obs_lat != 2) begin
      failures++; $display("FAIL write_latency: got %0d (timeout=%0d), want 2", obs_lat, obs_timeout);
    end
    checks++;
    if (obs_en != 1 || obs_seq_err) begin
      failures++; $display("FAIL write_pins: en_cycles=%0d seq_err=%0d, want 1 0", obs_en, obs_seq_err);
    end
    checks++;
    if (obs_found !== 1'b1 || obs_addr !== 5'd3) begin
      failures++; $display("FAIL write_resp: found=%b addr=%0d, want 1 3", obs_found, obs_addr);
    end
    checks++;
    if (obs_hs_err) begin
      failures++; $display("FAIL write_handshake: resp_valid/req_ready wrong after handshake");
    end
  endtask

  task automatic test_search_hit;
    logic ef;
    logic [ADDR_W-1:0] ea;
    run_cmd(2'b01, 5'd15, 8'h1F, 0);
    ref_apply(2'b01, 5'd15, 8'h1F);
    ref_search(8'h1F, ef, ea);
    run_cmd(2'b00, 5'd0, 8'h1F, 0);
    checks++;
    if (obs_timeout || obs_lat != 1 + int'(RESULT_LAT)) begin
      failures++; $display("FAIL search_latency: got %0d, want %0d", obs_lat, 1 + int'(RESULT_LAT));
    end
    checks++;
    if (obs_en != 1 || obs_seq_err) begin
      failures++; $display("FAIL search_pins: en_cycles=%0d seq_err=%0d, want 1 0", obs_en, obs_seq_err);
    end
    checks++;
    if (obs_found !== ef || obs_addr !== ea) begin
      failures++; $display("FAIL search_hit: found=%b addr=%0d, want %b %0d", obs_found, obs_addr, ef, ea);
    end
  endtask

  task automatic test_search_miss_hold;
    run_cmd(2'b00, 5'd0, 8'h55, 5);
    checks++;
    if (obs_timeout || obs_found !== 1'b0) begin
      failures++; $display("FAIL search_miss: found=%b timeout=%0d, want 0", obs_found, obs_timeout);
    end
    checks++;
    if (obs_stable_err || obs_ready_err) begin
      failures++; $display("FAIL resp_hold: stable_err=%0d ready_err=%0d, want 0 0", obs_stable_err, obs_ready_err);
    end
  endtask

  task automatic test_fill;
    logic ef;
    logic [ADDR_W-1:0] ea;
    run_cmd(2'b10, 5'd0, 8'hAA, 1);
    ref_apply(2'b10, 5'd0, 8'hAA);
    checks++;
    if (obs_en != int'(DEPTH) || obs_seq_err || obs_lat != int'(DEPTH)) begin
      failures++; $display("FAIL fill_sweep: en_cycles=%0d seq_err=%0d lat=%0d, want %0d 0 %0d",
                           obs_en, obs_seq_err, obs_lat, DEPTH, DEPTH);
    end
    checks++;
    if (obs_found !== 1'b1 || obs_addr !== ADDR_W'(DEPTH - 1)) begin
      failures++; $display("FAIL fill_resp: found=%b addr=%0d, want 1 %0d", obs_found, obs_addr, DEPTH - 1);
    end
    ref_search(8'hAA, ef, ea);
    run_cmd(2'b00, 5'd0, 8'hAA, 0);
    checks++;
    if (obs_found !== ef || obs_addr !== ea) begin
      failures++; $display("FAIL fill_search: found=%b addr=%0d, want %b %0d", obs_found, obs_addr, ef, ea);
    end
  endtask

  task automatic test_reserved;
    run_cmd(2'b11, 5'd9, 8'h77, 2);
    checks++;
    if (obs_timeout || obs_lat != 0 || obs_en != 0 || obs_found !== 1'b0 || obs_addr !== '0) begin
      failures++; $display("FAIL reserved: lat=%0d en_cycles=%0d found=%b addr=%0d, want 0 0 0 0",
                           obs_lat, obs_en, obs_found, obs_addr);
    end
  endtask

  task automatic test_fill_reset;
    bit seen, bad;
    logic ef;
    logic [ADDR_W-1:0] ea;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_data = 8'h3C;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (cam_enable && cam_addr == 5'd7) seen = 1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || cam_enable !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL fill_abort: seen7=%0d en=%b ready=%b rvalid=%b, want 1 0 1 0",
                           seen, cam_enable, req_ready, resp_valid);
    end
    for (int i = 0; i < 7; i++) begin ref_mem[i] = 8'h3C; ref_vld[i] = 1'b1; end
    exp_hits = 0;
    exp_miss = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || cam_enable !== 1'b0 || req_ready !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL fill_no_resume: activity seen after reset release, want none");
    end
    ref_search(8'h3C, ef, ea);
    run_cmd(2'b00, 5'd0, 8'h3C, 0);
    checks++;
    if (obs_found !== ef || obs_addr !== ea) begin
      failures++; $display("FAIL fill_partial: found=%b addr=%0d, want %b %0d", obs_found, obs_addr, ef, ea);
    end
    ref_search(8'hAA, ef, ea);
    run_cmd(2'b00, 5'd0, 8'hAA, 0);
    checks++;
    if (obs_found !== ef || obs_addr !== ea) begin
      failures++; $display("FAIL fill_tail: found=%b addr=%0d, want %b %0d", obs_found, obs_addr, ef, ea);
    end
  endtask

  task automatic test_random;
    logic [DATA_W-1:0] pool [6];
    logic [1:0] op;
    logic [ADDR_W-1:0] a, ea;
    logic [DATA_W-1:0] d;
    logic ef;
    int r;
    pool[0] = 8'h13; pool[1] = 8'h1F; pool[2] = 8'h3C; pool[3] = 8'hAA; pool[4] = 8'h55; pool[5] = 8'h9E;
    for (int n = 0; n < 40; n++) begin
      r  = int'($urandom_range(0, 9));
      op = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a  = ADDR_W'($urandom);
      d  = pool[$urandom_range(0, 5)];
      ref_search(d, ef, ea);
      run_cmd(op, a, d, int'($urandom_range(0, 3)));
      ref_apply(op, a, d);
      if (op == 2'b01) begin ef = 1'b1; ea = a; end
      if (op == 2'b10) begin ef = 1'b1; ea = ADDR_W'(DEPTH - 1); end
      if (op == 2'b11) begin ef = 1'b0; ea = '0; end
      checks++;
      if (obs_timeout || obs_lat != exp_lat(op) || obs_en != exp_en(op) || obs_seq_err) begin
        failures++; $display("FAIL rand_timing[%0d] op=%0d: lat=%0d en=%0d seq_err=%0d, want %0d %0d 0",
                             n, op, obs_lat, obs_en, obs_seq_err, exp_lat(op), exp_en(op));
      end
      checks++;
      if (obs_found !== ef || (ef && obs_addr !== ea) || (op == 2'b11 && obs_addr !== '0)) begin
        failures++; $display("FAIL rand_resp[%0d] op=%0d: found=%b addr=%0d, want %b %0d",
                             n, op, obs_found, obs_addr, ef, ea);
      end
      checks++;
      if (obs_stable_err || obs_ready_err || obs_hs_err) begin
        failures++; $display("FAIL rand_handshake[%0d]: stable=%0d ready=%0d hs=%0d, want 0 0 0",
                             n, obs_stable_err, obs_ready_err, obs_hs_err);
      end
    end
  endtask

  task automatic test_stats;
`ifdef CAM_CTRL_STATS_EN
    checks++;
    if (int'(stat_hits) != exp_hits || int'(stat_miss) != exp_miss) begin
      failures++; $display("FAIL stats: hits=%0d miss=%0d, want %0d %0d", stat_hits, stat_miss, exp_hits, exp_miss);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < int'(NENT); i++) ref_vld[i] = 1'b0;
    test_reset;
    test_write;
    test_search_hit;
    test_search_miss_hold;
    test_fill;
    test_reserved;
    test_fill_reset;
    test_random;
    test_stats;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
